// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command-bus arbiter: init hold-off, fixed-priority grant, pin mux
module sdram_arbit #(
    parameter logic [11:0] IDLE_ADDR = 12'hFFF,
    parameter logic [1:0]  IDLE_BA   = 2'b11
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [11:0] init_addr,
    input  logic        refr_req,
    input  logic        refr_end,
    input  logic [3:0]  refr_cmd,
    input  logic [11:0] refr_addr,
    output logic        refr_en,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_ba,
    input  logic [11:0] wr_addr,
    input  logic        wr_sdram_en,
    input  logic [15:0] wr_data,
    output logic        wr_en,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_ba,
    input  logic [11:0] rd_addr,
    output logic        rd_en,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [11:0] sdram_addr,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe
);

    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARBIT,
        S_AREF,
        S_WRITE,
        S_READ
    } state_t;

    state_t      r_state;
    logic [3:0]  w_cmd;
    logic [1:0]  w_ba;
    logic [11:0] w_addr;

    // Owners are never preempted; only their own end pulse returns the bus to ARBIT.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (init_end) r_state <= S_ARBIT;
                S_ARBIT: begin
                    if (refr_req)    r_state <= S_AREF;
                    else if (wr_req) r_state <= S_WRITE;
                    else if (rd_req) r_state <= S_READ;
                end
                S_AREF:  if (refr_end) r_state <= S_ARBIT;
                S_WRITE: if (wr_end)   r_state <= S_ARBIT;
                S_READ:  if (rd_end)   r_state <= S_ARBIT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_cmd  = CMD_NOP;
        w_ba   = IDLE_BA;
        w_addr = IDLE_ADDR;
        case (r_state)
            S_IDLE: begin
                w_cmd  = init_cmd;
                w_addr = init_addr;
            end
            S_AREF: begin
                w_cmd  = refr_cmd;
                w_addr = refr_addr;
            end
            S_WRITE: begin
                w_cmd  = wr_cmd;
                w_ba   = wr_ba;
                w_addr = wr_addr;
            end
            S_READ: begin
                w_cmd  = rd_cmd;
                w_ba   = rd_ba;
                w_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign refr_en = (r_state == S_AREF);
    assign wr_en   = (r_state == S_WRITE);
    assign rd_en   = (r_state == S_READ);

    assign sdram_cke = 1'b1;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_cmd;
    assign sdram_ba   = w_ba;
    assign sdram_addr = w_addr;

    assign sdram_dq_oe  = (r_state == S_WRITE) && wr_sdram_en;
    assign sdram_dq_out = sdram_dq_oe ? wr_data : 16'h0000;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - randomized and directed bench for sdram_arbit against an owner-based model
module tb_sdram_arbit;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;
    logic        refr_req, refr_end;
    logic [3:0]  refr_cmd;
    logic [11:0] refr_addr;
    logic        refr_en;
    logic        wr_req, wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [11:0] wr_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [11:0] rd_addr;
    logic        rd_en;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [11:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;

    int checks = 0;
    int errors = 0;

    // Who owns the bus: nobody yet (before init), free, or one of the three sources.
    localparam int UNINIT = 0, FREE = 1, SRC_REFR = 2, SRC_WR = 3, SRC_RD = 4;
    int owner = UNINIT;

    always #5 sys_clk = ~sys_clk;

    sdram_arbit dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
        .refr_req(refr_req), .refr_end(refr_end), .refr_cmd(refr_cmd),
        .refr_addr(refr_addr), .refr_en(refr_en),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba),
        .wr_addr(wr_addr), .wr_sdram_en(wr_sdram_en), .wr_data(wr_data), .wr_en(wr_en),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba),
        .rd_addr(rd_addr), .rd_en(rd_en),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
        .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    wire [2:0]  w_grants = {refr_en, wr_en, rd_en};
    wire [3:0]  w_cmd    = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    wire [38:0] w_dut    = {w_grants, sdram_cke, w_cmd, sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe};

    function automatic logic [38:0] model_out();
        logic [3:0]  c;
        logic [1:0]  b;
        logic [11:0] a;
        logic        oe;
        c = 4'b0111; b = 2'b11; a = 12'hFFF; oe = 1'b0;
        if (owner == UNINIT)   begin c = init_cmd; a = init_addr; end
        if (owner == SRC_REFR) begin c = refr_cmd; a = refr_addr; end
        if (owner == SRC_WR)   begin c = wr_cmd; a = wr_addr; b = wr_ba; oe = wr_sdram_en; end
        if (owner == SRC_RD)   begin c = rd_cmd; a = rd_addr; b = rd_ba; end
        return {owner == SRC_REFR, owner == SRC_WR, owner == SRC_RD, 1'b1,
                c, b, a, (oe ? wr_data : 16'h0000), oe};
    endfunction

    // One clock: apply the ownership rules to the inputs present at the edge.
    task automatic step();
        @(posedge sys_clk);
        if (!sys_rst_n)          owner = UNINIT;
        else if (owner == UNINIT) begin if (init_end) owner = FREE; end
        else if (owner == FREE) begin
            if (refr_req)    owner = SRC_REFR;
            else if (wr_req) owner = SRC_WR;
            else if (rd_req) owner = SRC_RD;
        end
        else if ((owner == SRC_REFR && refr_end) || (owner == SRC_WR && wr_end) ||
                 (owner == SRC_RD && rd_end))
            owner = FREE;
        #1;
    endtask

    task automatic clear_inputs();
        refr_req = 0; refr_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
        wr_sdram_en = 0; wr_data = 16'h1234;
        refr_cmd = 4'b0010; refr_addr = 12'h400;
        wr_cmd = 4'b0100; wr_ba = 2'b01; wr_addr = 12'h123;
        rd_cmd = 4'b0101; rd_ba = 2'b10; rd_addr = 12'h321;
    endtask

    task automatic test_reset();
        sys_rst_n = 0; init_end = 0; init_cmd = 4'b0010; init_addr = 12'h400;
        clear_inputs();
        #2;
        checks++;
        if (w_dut !== {3'b000, 1'b1, 4'b0010, 2'b11, 12'h400, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL reset_state: got %h want %h", w_dut,
                {3'b000, 1'b1, 4'b0010, 2'b11, 12'h400, 16'h0000, 1'b0});
        end
        @(negedge sys_clk); sys_rst_n = 1;
    endtask

    task automatic test_init();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (w_dut !== model_out() || w_cmd !== 4'b0010 || w_grants !== 3'b000) begin
                errors++; $display("FAIL init_hold: got %h want %h", w_dut, model_out());
            end
        end
        init_end = 1;
        step();
        checks++;
        if (w_cmd !== 4'b0111 || sdram_addr !== 12'hFFF || w_dut !== model_out()) begin
            errors++; $display("FAIL init_done: got %h want %h", w_dut, model_out());
        end
    endtask

    task automatic test_refresh();
        refr_req = 1; refr_cmd = 4'b0010;
        step();
        checks++;
        if (refr_en !== 1'b1 || w_cmd !== 4'b0010 || w_dut !== model_out()) begin
            errors++; $display("FAIL refr_grant: got %h want %h", w_dut, model_out());
        end
        refr_cmd = 4'b0001;
        step();
        checks++;
        if (w_cmd !== 4'b0001 || w_dut !== model_out()) begin
            errors++; $display("FAIL refr_aref_cmd: got %h want %h", w_dut, model_out());
        end
        refr_end = 1;
        step();
        refr_req = 0;
        checks++;
        if (refr_en !== 1'b0 || w_cmd !== 4'b0111 || w_dut !== model_out()) begin
            errors++; $display("FAIL refr_release: got %h want %h", w_dut, model_out());
        end
        step();
        checks++;
        if (w_grants !== 3'b000 || w_dut !== model_out()) begin
            errors++; $display("FAIL refr_end_ignored: got %h want %h", w_dut, model_out());
        end
        refr_end = 0;
    endtask

    task automatic test_priority();
        logic [2:0] exp_seq [6];
        exp_seq = '{3'b100, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000};
        refr_req = 1; wr_req = 1; rd_req = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            refr_end = 0; wr_end = 0; rd_end = 0;
            if (i == 1) refr_req = 0;
            if (i == 3) wr_req = 0;
            if (i == 5) rd_req = 0;
            checks++;
            if (w_grants !== exp_seq[i] || w_dut !== model_out()) begin
                errors++; $display("FAIL priority_%0d: grants %b want %b", i, w_grants, exp_seq[i]);
            end
            if (i == 0) refr_end = 1;
            if (i == 2) wr_end = 1;
            if (i == 4) rd_end = 1;
        end
    endtask

    task automatic test_no_preempt();
        wr_req = 1;
        step();
        wr_req = 0; refr_req = 1; rd_req = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (w_grants !== 3'b010 || w_dut !== model_out()) begin
                errors++; $display("FAIL no_preempt_%0d: grants %b want 010", i, w_grants);
            end
        end
        wr_end = 1;
        step();
        wr_end = 0;
        step();
        checks++;
        if (w_grants !== 3'b100 || w_dut !== model_out()) begin
            errors++; $display("FAIL preempt_refr_next: grants %b want 100", w_grants);
        end
        refr_end = 1;
        step();
        refr_req = 0; refr_end = 0; rd_req = 0;
        step();
    endtask

    task automatic test_dq();
        wr_req = 1;
        step();
        wr_req = 0; wr_sdram_en = 1; wr_data = 16'hA5A5;
        #1;
        checks++;
        if (sdram_dq_oe !== 1'b1 || sdram_dq_out !== 16'hA5A5 || w_dut !== model_out()) begin
            errors++; $display("FAIL dq_write: oe %b dq %h want 1 a5a5", sdram_dq_oe, sdram_dq_out);
        end
        wr_end = 1;
        step();
        wr_end = 0; rd_req = 1;
        step();
        rd_req = 0;
        checks++;
        if (rd_en !== 1'b1 || sdram_dq_oe !== 1'b0 || sdram_dq_out !== 16'h0000 || w_dut !== model_out()) begin
            errors++; $display("FAIL dq_read: got %h want %h", w_dut, model_out());
        end
        rd_end = 1;
        step();
        rd_end = 0; wr_sdram_en = 0;
    endtask

    task automatic test_reset_mid_write();
        wr_req = 1; wr_sdram_en = 1;
        step();
        #2;
        sys_rst_n = 0; owner = UNINIT; init_end = 0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || sdram_dq_oe !== 1'b0 || w_dut !== model_out()) begin
            errors++; $display("FAIL reset_mid_write: got %h want %h", w_dut, model_out());
        end
        @(negedge sys_clk); sys_rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (w_grants !== 3'b000 || w_dut !== model_out()) begin
                errors++; $display("FAIL post_reset_hold_%0d: grants %b want 000", i, w_grants);
            end
        end
        init_end = 1;
        step();
        step();
        checks++;
        if (wr_en !== 1'b1 || w_dut !== model_out()) begin
            errors++; $display("FAIL post_reset_resume: got %h want %h", w_dut, model_out());
        end
        wr_req = 0; wr_end = 1;
        step();
        wr_end = 0; wr_sdram_en = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            refr_req = ($urandom_range(0, 3) == 0);
            wr_req   = $urandom_range(0, 1);
            rd_req   = $urandom_range(0, 1);
            refr_end = ($urandom_range(0, 3) == 0);
            wr_end   = ($urandom_range(0, 3) == 0);
            rd_end   = ($urandom_range(0, 3) == 0);
            init_end = ($urandom_range(0, 7) != 0);
            wr_sdram_en = $urandom_range(0, 1);
            wr_data  = 16'($urandom);
            init_cmd = 4'($urandom); init_addr = 12'($urandom);
            refr_cmd = 4'($urandom); refr_addr = 12'($urandom);
            wr_cmd = 4'($urandom); wr_ba = 2'($urandom); wr_addr = 12'($urandom);
            rd_cmd = 4'($urandom); rd_ba = 2'($urandom); rd_addr = 12'($urandom);
            step();
            checks++;
            if (w_dut !== model_out()) begin
                errors++; $display("FAIL random_%0d: got %h want %h", i, w_dut, model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_refresh();
        test_priority();
        test_no_preempt();
        test_dq();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Central arbiter of the SDRAM controller. It holds off all traffic until power-up initialisation finishes. It then grants the SDRAM command bus to exactly one of three requesters (auto-refresh, write, read) using fixed priority, and muxes the granted source's command, bank, address and write data onto the SDRAM pins. It is the grant side of the `refr_req`/`refr_en`/`refr_end` handshake driven by the auto-refresh block, and the equivalent handshakes of the write and read blocks.

## Interface
Parameters:
- `IDLE_ADDR`, default 12'hFFF: address driven while no source owns the bus.
- `IDLE_BA`, default 2'b11: bank driven while no source owns the bus.

Ports:
- `sys_clk` in 1: system clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `init_end` in 1: level; initialisation sequence complete.
- `init_cmd` in 4: initialisation command {cs_n,ras_n,cas_n,we_n}.
- `init_addr` in 12: initialisation address.
- `refr_req` in 1: refresh request; held high until `refr_end`.
- `refr_end` in 1: refresh sequence done.
- `refr_cmd` in 4: refresh command.
- `refr_addr` in 12: refresh address.
- `refr_en` out 1: refresh grant.
- `wr_req` in 1: write request.
- `wr_end` in 1: write done.
- `wr_cmd` in 4: write command.
- `wr_ba` in 2: write bank.
- `wr_addr` in 12: write address.
- `wr_sdram_en` in 1: write data valid on the bus.
- `wr_data` in 16: write data.
- `wr_en` out 1: write grant.
- `rd_req` in 1: read request.
- `rd_end` in 1: read done.
- `rd_cmd` in 4: read command.
- `rd_ba` in 2: read bank.
- `rd_addr` in 12: read address.
- `rd_en` out 1: read grant.
- `sdram_cke` out 1: clock enable; constant 1.
- `sdram_cs_n`, `sdram_ras_n`, `sdram_cas_n`, `sdram_we_n` out 1 each: command pins.
- `sdram_ba` out 2: bank.
- `sdram_addr` out 12: address.
- `sdram_dq_out` out 16: DQ drive value.
- `sdram_dq_oe` out 1: DQ output enable.

## Operation
- **Command encoding:** {cs_n,ras_n,cas_n,we_n}. NOP=0111, PRE=0010, AREF=0001.
- **States:** single registered state machine with five states: IDLE, ARBIT, AREF, WRITE, READ. Reset state is IDLE.
- **IDLE:** go to ARBIT when `init_end`=1; otherwise stay.
- **ARBIT:** priority order is `refr_req`, then `wr_req`, then `rd_req`.
  - `refr_req`=1: go to AREF.
  - else `wr_req`=1: go to WRITE.
  - else `rd_req`=1: go to READ.
  - else stay.
- **Busy states:**
  - AREF: return to ARBIT on `refr_end`=1.
  - WRITE: return to ARBIT on `wr_end`=1.
  - READ: return to ARBIT on `rd_end`=1.
  - No preemption. A higher-priority request waits for the current owner's end pulse.
- **End pulses:** an `*_end` is honoured only in its own state. `refr_end`, `wr_end` and `rd_end` seen in any other state are ignored.
- **Grants:** combinational decode of the state register. `refr_en`=(state==AREF), `wr_en`=(state==WRITE), `rd_en`=(state==READ). At most one grant is high.
- **Pin mux (combinational, from state):**
  - IDLE: `init_cmd`, `init_addr`, ba=`IDLE_BA`.
  - ARBIT: NOP, `IDLE_ADDR`, `IDLE_BA`.
  - AREF: `refr_cmd`, `refr_addr`, `IDLE_BA`.
  - WRITE: `wr_cmd`, `wr_addr`, `wr_ba`.
  - READ: `rd_cmd`, `rd_addr`, `rd_ba`.
- **DQ:**
  - `sdram_dq_oe`=(state==WRITE)&&`wr_sdram_en`.
  - `sdram_dq_out`=`wr_data` when `sdram_dq_oe`=1, else 16'h0000.
- **Starvation:** the refresh source requests every 750 cycles. Write/read blocks bound their own occupancy so that a refresh waits less than one refresh period. The arbiter does not enforce this.

## Timing
- **Reset values:**
  - state=IDLE.
  - `refr_en`=`wr_en`=`rd_en`=0.
  - `sdram_dq_oe`=0, `sdram_dq_out`=0.
  - `sdram_cke`=1.
  - Command/address pins follow `init_cmd`/`init_addr`; `sdram_ba`=2'b11.
- **Grant latency:** a request sampled high in ARBIT at edge N gives a grant high after edge N, i.e. one cycle.
- **Release:** `*_end` sampled high at edge M drops the grant after edge M. The bus is in ARBIT (NOP) for at least one cycle between two owners.
- **Refresh handshake:** the refresh source clears `refr_req` on the same edge the arbiter leaves AREF. `refr_end` stays high while in ARBIT until the source sees `refr_en`=0, and is ignored there.
- **Simultaneous requests:** resolved in one ARBIT cycle by the priority order. Losers stay pending and are re-evaluated at the next ARBIT.
- **`init_end` drop:** `init_end` falling after IDLE has been left has no effect.
- **Reset mid-operation:** asynchronous return to IDLE. Grants and `dq_oe` drop immediately. Traffic resumes only after `init_end`=1 is seen again.

## Test plan
- **Initialisation:** hold `init_end`=0 with `init_cmd`=0010, `init_addr`=12'h400 → pins=0010, addr=12'h400, ba=11, all grants 0. Raise `init_end` → next cycle pins=0111, addr=12'hFFF.
- **Refresh handshake:** `refr_req`=1 in ARBIT → `refr_en`=1 next cycle and `refr_cmd` 0010 then 0001 appear on the pins. `refr_end`=1 → `refr_en`=0 next cycle, pins=0111.
- **Priority:** `refr_req`, `wr_req`, `rd_req` all 1 in the same cycle → grant sequence `refr_en`, then `wr_en` (after `refr_end`), then `rd_en` (after `wr_end`), with one NOP cycle between each.
- **No preemption:** raise `refr_req` while WRITE is active → `wr_en` holds until `wr_end`. Then `refr_en`=1 even though `rd_req`=1.
- **DQ path:** in WRITE with `wr_sdram_en`=1, `wr_data`=16'hA5A5 → same cycle `dq_oe`=1, `dq_out`=16'hA5A5. In READ → `dq_oe`=0.
- **Reset mid-write:** drop `sys_rst_n` during WRITE → `wr_en`=0 and `dq_oe`=0 immediately. After release, no grant is issued until `init_end`=1.
